// File: rtl/demux_pkg.sv
// Shared types and index helpers for the lane demultiplexer.
package demux_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   // Output channel of lane l, beat p: all beats of one lane are contiguous.
   function automatic int ch_idx(input int l, input int p, input int ratio);
      return l * ratio + p;
   endfunction

   function automatic int phase_w(input int ratio);
      return (ratio <= 1) ? 1 : $clog2(ratio);
   endfunction

endpackage

// File: rtl/demux_phase_ctrl.sv
// Beat phase counter with optional idle/run alignment FSM; decides when
// the staging slots capture and when a full group is emitted.
module demux_phase_ctrl
   import demux_pkg::*;
#(
   parameter int RATIO          = 2,
   parameter bit ALIGN_ON_VALID = 1'b1,
   parameter int PW             = 1
) (
   input  logic          clk_2f,
   input  logic          reset_L,
   input  logic          any_valid_i,
   input  logic          grp_valid_i,
   output logic [PW-1:0] phase_o,
   output logic          capture_en_o,
   output logic          emit_o
);

   localparam logic [PW-1:0] LAST = PW'(RATIO - 1);

   state_e        state_q, state_d;
   logic [PW-1:0] phase_q, phase_d;
   logic          last;

   assign last    = (phase_q == LAST);
   assign phase_o = phase_q;

   always_comb begin
      state_d      = state_q;
      phase_d      = phase_q;
      capture_en_o = 1'b0;
      emit_o       = 1'b0;
      case (state_q)
         IDLE: begin
            // Phase is parked at 0 here, so the waking beat lands in slot 0.
            if (any_valid_i) begin
               capture_en_o = 1'b1;
               emit_o       = last;
               phase_d      = last ? '0 : phase_q + PW'(1);
               state_d      = RUN;
            end
         end
         RUN: begin
            capture_en_o = 1'b1;
            emit_o       = last;
            phase_d      = last ? '0 : phase_q + PW'(1);
            if (ALIGN_ON_VALID && last && !grp_valid_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_2f) begin
      if (!reset_L) begin
         state_q <= ALIGN_ON_VALID ? IDLE : RUN;
         phase_q <= '0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
      end
   end

endmodule

// File: rtl/demux_lanes_param.sv
// Splits each of LANES byte lanes into RATIO channels and presents all
// LANES*RATIO channels together once per group, with a one-cycle strobe.
module demux_lanes_param
   import demux_pkg::*;
#(
   parameter int DATA_W         = 8,
   parameter int LANES          = 2,
   parameter int RATIO          = 2,
   parameter bit ALIGN_ON_VALID = 1'b1
) (
   input  logic                          clk_2f,
   input  logic                          reset_L,
   input  logic [LANES*DATA_W-1:0]       data_in,
   input  logic [LANES-1:0]              valid_in,
   output logic [LANES*RATIO*DATA_W-1:0] data_out,
   output logic [LANES*RATIO-1:0]        valid_out,
   output logic                          out_stb,
   output logic [15:0]                   grp_cnt
);

   localparam int NCH = LANES * RATIO;
   localparam int PW  = phase_w(RATIO);

   logic [PW-1:0]         phase;
   logic                  capture_en, emit, grp_valid;
   logic [NCH*DATA_W-1:0] stage_q, stage_d, grp_data, data_q;
   logic [NCH-1:0]        svalid_q, svalid_d, grp_vld, valid_q;
   logic                  stb_q;
   logic [15:0]           cnt_q;

   demux_phase_ctrl #(
      .RATIO          (RATIO),
      .ALIGN_ON_VALID (ALIGN_ON_VALID),
      .PW             (PW)
   ) u_ctrl (
      .clk_2f       (clk_2f),
      .reset_L      (reset_L),
      .any_valid_i  (|valid_in),
      .grp_valid_i  (grp_valid),
      .phase_o      (phase),
      .capture_en_o (capture_en),
      .emit_o       (emit)
   );

   // The last beat of a group goes straight to the output; earlier beats
   // come from staging. Invalid beats leave the slot's data untouched.
   always_comb begin
      stage_d  = stage_q;
      svalid_d = svalid_q;
      grp_data = stage_q;
      grp_vld  = svalid_q;
      for (int l = 0; l < LANES; l++) begin
         for (int p = 0; p < RATIO; p++) begin
            if (p == RATIO - 1) begin
               grp_vld[ch_idx(l, p, RATIO)] = valid_in[l];
               if (valid_in[l])
                  grp_data[ch_idx(l, p, RATIO)*DATA_W +: DATA_W] = data_in[l*DATA_W +: DATA_W];
            end
            if (capture_en && phase == PW'(p)) begin
               svalid_d[ch_idx(l, p, RATIO)] = valid_in[l];
               if (valid_in[l])
                  stage_d[ch_idx(l, p, RATIO)*DATA_W +: DATA_W] = data_in[l*DATA_W +: DATA_W];
            end
         end
      end
      grp_valid = |grp_vld;
   end

   always_ff @(posedge clk_2f) begin
      if (!reset_L) begin
         stage_q  <= '0;
         svalid_q <= '0;
         data_q   <= '0;
         valid_q  <= '0;
         stb_q    <= 1'b0;
         cnt_q    <= '0;
      end else begin
         stage_q  <= stage_d;
         svalid_q <= svalid_d;
         stb_q    <= emit;
         if (emit) begin
            data_q  <= grp_data;
            valid_q <= grp_vld;
            if (grp_valid) cnt_q <= cnt_q + 16'd1;
         end
      end
   end

   assign data_out  = data_q;
   assign valid_out = valid_q;
   assign out_stb   = stb_q;
   assign grp_cnt   = cnt_q;

endmodule

// File: tb/tb_demux_lanes_param.sv
// Directed bench for demux_lanes_param across four parameter sets.
module tb_demux_lanes_param;

   typedef struct {
      logic        rst_n;
      logic [1:0]  vin;
      logic [15:0] din;
      logic        stb;
      logic [3:0]  vout;
      logic [31:0] dout;
      logic [15:0] cnt;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // u0: defaults (align on), u1: free-running phase, u2: 4x4x16, u3: RATIO=1
   logic [15:0]  din0, din1, din3;
   logic [1:0]   vin0, vin1, vin3;
   logic [31:0]  dout0, dout1;
   logic [3:0]   vout0, vout1;
   logic         stb0, stb1, stb2, stb3;
   logic [15:0]  cnt0, cnt1, cnt2, cnt3;
   logic [63:0]  din2;
   logic [3:0]   vin2;
   logic [255:0] dout2;
   logic [15:0]  vout2;
   logic [15:0]  dout3;
   logic [1:0]   vout3;

   demux_lanes_param #(.DATA_W(8), .LANES(2), .RATIO(2), .ALIGN_ON_VALID(1'b1)) u0 (
      .clk_2f(clk), .reset_L(rst_n), .data_in(din0), .valid_in(vin0),
      .data_out(dout0), .valid_out(vout0), .out_stb(stb0), .grp_cnt(cnt0));
   demux_lanes_param #(.DATA_W(8), .LANES(2), .RATIO(2), .ALIGN_ON_VALID(1'b0)) u1 (
      .clk_2f(clk), .reset_L(rst_n), .data_in(din1), .valid_in(vin1),
      .data_out(dout1), .valid_out(vout1), .out_stb(stb1), .grp_cnt(cnt1));
   demux_lanes_param #(.DATA_W(16), .LANES(4), .RATIO(4), .ALIGN_ON_VALID(1'b1)) u2 (
      .clk_2f(clk), .reset_L(rst_n), .data_in(din2), .valid_in(vin2),
      .data_out(dout2), .valid_out(vout2), .out_stb(stb2), .grp_cnt(cnt2));
   demux_lanes_param #(.DATA_W(8), .LANES(2), .RATIO(1), .ALIGN_ON_VALID(1'b1)) u3 (
      .clk_2f(clk), .reset_L(rst_n), .data_in(din3), .valid_in(vin3),
      .data_out(dout3), .valid_out(vout3), .out_stb(stb3), .grp_cnt(cnt3));

   int n_cmp = 0;
   int n_err = 0;
   vec_t tbl[$];
   logic [15:0] exp_q[$];

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp_v);
      n_cmp++;
      if (act !== exp_v) begin
         n_err++;
         $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp_v);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic add(input logic r, input logic [1:0] vi, input logic [15:0] di, input logic s,
                      input logic [3:0] vo, input logic [31:0] dout, input logic [15:0] c);
      vec_t v;
      v.rst_n = r; v.vin = vi; v.din = di; v.stb = s; v.vout = vo; v.dout = dout; v.cnt = c;
      tbl.push_back(v);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [255:0] exp2;
      logic [15:0]  d;
      rst_n = 1'b0;
      din0 = '0; vin0 = '0; din1 = '0; vin1 = '0;
      din2 = '0; vin2 = '0; din3 = '0; vin3 = '0;

      // reset, two full groups, a mixed-valid group, idle return, realign, reset mid-group
      add(0, 2'b00, 16'h0000, 0, 4'h0, 32'h00000000, 0);
      add(0, 2'b00, 16'h0000, 0, 4'h0, 32'h00000000, 0);
      add(0, 2'b00, 16'h0000, 0, 4'h0, 32'h00000000, 0);
      add(1, 2'b11, 16'hddff, 0, 4'h0, 32'h00000000, 0);
      add(1, 2'b11, 16'hccee, 1, 4'hf, 32'hccddeeff, 1);
      add(1, 2'b11, 16'hddff, 0, 4'hf, 32'hccddeeff, 1);
      add(1, 2'b11, 16'hccee, 1, 4'hf, 32'hccddeeff, 2);
      add(1, 2'b11, 16'h99bb, 0, 4'hf, 32'hccddeeff, 2);
      add(1, 2'b11, 16'h88aa, 1, 4'hf, 32'h8899aabb, 3);
      add(1, 2'b10, 16'h7711, 0, 4'hf, 32'h8899aabb, 3);
      add(1, 2'b00, 16'h2233, 1, 4'h4, 32'h8877aabb, 4);
      add(1, 2'b00, 16'h0000, 0, 4'h4, 32'h8877aabb, 4);
      add(1, 2'b00, 16'h0000, 1, 4'h0, 32'h8877aabb, 4);
      for (int i = 0; i < 5; i++) add(1, 2'b00, 16'h0000, 0, 4'h0, 32'h8877aabb, 4);
      add(1, 2'b01, 16'h005a, 0, 4'h0, 32'h8877aabb, 4);
      add(1, 2'b00, 16'h0000, 1, 4'h1, 32'h8877aa5a, 5);
      add(1, 2'b00, 16'h0000, 0, 4'h1, 32'h8877aa5a, 5);
      add(1, 2'b00, 16'h0000, 1, 4'h0, 32'h8877aa5a, 5);
      add(1, 2'b00, 16'h0000, 0, 4'h0, 32'h8877aa5a, 5);
      add(1, 2'b11, 16'h1234, 0, 4'h0, 32'h8877aa5a, 5);
      add(0, 2'b11, 16'h5678, 0, 4'h0, 32'h00000000, 0);
      add(1, 2'b11, 16'h9abc, 0, 4'h0, 32'h00000000, 0);
      add(1, 2'b11, 16'hdef0, 1, 4'hf, 32'hde9af0bc, 1);
      add(1, 2'b00, 16'h0000, 0, 4'hf, 32'hde9af0bc, 1);
      add(1, 2'b01, 16'h0044, 1, 4'h2, 32'hde9a44bc, 2);
      add(1, 2'b00, 16'h0000, 0, 4'h2, 32'hde9a44bc, 2);
      add(1, 2'b00, 16'h0000, 1, 4'h0, 32'hde9a44bc, 2);
      add(1, 2'b00, 16'h0000, 0, 4'h0, 32'hde9a44bc, 2);

      @(negedge clk);
      foreach (tbl[i]) begin
         rst_n = tbl[i].rst_n;
         vin0  = tbl[i].vin;
         din0  = tbl[i].din;
         step();
         chk($sformatf("u0_stb[%0d]", i),  256'(stb0),  256'(tbl[i].stb));
         chk($sformatf("u0_vout[%0d]", i), 256'(vout0), 256'(tbl[i].vout));
         chk($sformatf("u0_dout[%0d]", i), 256'(dout0), 256'(tbl[i].dout));
         chk($sformatf("u0_cnt[%0d]", i),  256'(cnt0),  256'(tbl[i].cnt));
      end
      vin0 = '0; din0 = '0;

      // free-running phase: strobe every second cycle, nothing counted
      rst_n = 1'b0;
      step();
      chk("u1_reset_stb", 256'(stb1), 256'(0));
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         chk($sformatf("u1_stb[%0d]", i),  256'(stb1),  256'(i % 2 == 1));
         chk($sformatf("u1_vout[%0d]", i), 256'(vout1), 256'(0));
         chk($sformatf("u1_dout[%0d]", i), 256'(dout1), 256'(0));
         chk($sformatf("u1_cnt[%0d]", i),  256'(cnt1),  256'(0));
      end

      // 4 lanes x 4 beats of 16-bit ramp, two groups
      for (int g = 0; g < 2; g++) begin
         for (int p = 0; p < 4; p++) begin
            for (int l = 0; l < 4; l++) din2[l*16 +: 16] = 16'(g*16 + l*4 + p + 1);
            vin2 = 4'hf;
            step();
            chk($sformatf("u2_stb[%0d.%0d]", g, p), 256'(stb2), 256'(p == 3));
            if (p == 3) begin
               for (int k = 0; k < 16; k++) exp2[k*16 +: 16] = 16'(g*16 + k + 1);
               chk($sformatf("u2_dout[%0d]", g), dout2, exp2);
               chk($sformatf("u2_vout[%0d]", g), 256'(vout2), 256'(16'hffff));
               chk($sformatf("u2_cnt[%0d]", g),  256'(cnt2),  256'(g + 1));
            end
         end
      end
      vin2 = '0;

      // RATIO=1: registered pass-through every cycle
      for (int i = 0; i < 8; i++) begin
         d = 16'(i * 16'h1357 + 16'h0a0b);
         din3 = d;
         vin3 = 2'b11;
         exp_q.push_back(d);
         step();
         chk($sformatf("u3_stb[%0d]", i),  256'(stb3),  256'(1));
         chk($sformatf("u3_vout[%0d]", i), 256'(vout3), 256'(2'b11));
         chk($sformatf("u3_dout[%0d]", i), 256'(dout3), 256'(exp_q.pop_front()));
         chk($sformatf("u3_cnt[%0d]", i),  256'(cnt3),  256'(i + 1));
      end
      vin3 = 2'b00;
      step();
      chk("u3_idle_emit_stb",  256'(stb3),  256'(1));
      chk("u3_idle_emit_vout", 256'(vout3), 256'(0));
      step();
      chk("u3_idle_stb", 256'(stb3), 256'(0));
      chk("u3_idle_cnt", 256'(cnt3), 256'(8));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
